// File: rtl/player_buzzer_arbiter.sv
// Player buzzer front end: synchronizes the four buzzer buttons and the
// answer switches, debounces the buttons, and latches the first player to
// buzz until software clears the capture.
// Optional build macro REPEAT_LOCKOUT_EN: blocks a player who has just been
// serviced from capturing again until someone else wins a round.
module player_buzzer_arbiter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_SW          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        buttonsRaw,
  input  logic [NUM_SW-1:0] switchRaw,
  input  logic              gameHasStarted,
  input  logic              clearFlag,
  output logic              playerInputFlag,
  output logic [1:0]        firstPlayerFlag,
  output logic              allButtons,
  output logic [NUM_SW-1:0] switchInput
);

  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [3:0]        r_btn_s1;
  logic [3:0]        r_btn_s2;
  logic [NUM_SW-1:0] r_sw_s1;
  logic [NUM_SW-1:0] r_sw_s2;
  logic [CNT_W-1:0]  r_cnt [4];
  logic [3:0]        r_deb;
  logic [3:0]        r_deb_d;
  logic              r_all;
  logic [1:0]        r_state;
  logic              r_pif;
  logic [1:0]        r_fpf;
  logic [3:0]        w_rise;
  logic [3:0]        w_rise_eff;
  logic [1:0]        w_win;

  // Two-flop synchronizers for buttons and switches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= buttonsRaw;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= switchRaw;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // Per-button debounce: level flips only after a full run of disagreement
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_all   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_btn_s2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_deb[i] <= ~r_deb[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
      r_deb_d <= r_deb;
      r_all   <= &r_deb;
    end
  end

  assign w_rise = r_deb & ~r_deb_d;

`ifdef REPEAT_LOCKOUT_EN
  logic [3:0] r_mask;

  // Lockout mask: remembers retired winners until a different player wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '0;
    end else if (!gameHasStarted) begin
      r_mask <= '0;
    end else if ((r_state == S_ARMED) && (|w_rise_eff)) begin
      r_mask <= '0;
    end else if ((r_state == S_LOCKED) && clearFlag) begin
      r_mask[r_fpf] <= 1'b1;
    end
  end

  assign w_rise_eff = w_rise & ~r_mask;
`else
  assign w_rise_eff = w_rise;
`endif

  // Fixed priority: lowest player index wins simultaneous rises
  always_comb begin
    w_win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_rise_eff[i]) w_win = 2'(i);
    end
  end

  // Arbitration FSM: arm, capture first rise, hold until cleared, wait for release
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pif   <= 1'b0;
      r_fpf   <= 2'd0;
    end else if (!gameHasStarted) begin
      r_state <= S_IDLE;
      r_pif   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_ARMED;
        S_ARMED: begin
          if (|w_rise_eff) begin
            r_fpf   <= w_win;
            r_pif   <= 1'b1;
            r_state <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (clearFlag) begin
            r_pif   <= 1'b0;
            r_state <= (|r_deb) ? S_RELEASE : S_ARMED;
          end
        end
        S_RELEASE: begin
          if (r_deb == 4'd0) r_state <= S_ARMED;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign playerInputFlag = r_pif;
  assign firstPlayerFlag = r_fpf;
  assign allButtons      = r_all;
  assign switchInput     = r_sw_s2;

endmodule
